// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared definitions for the single-precision FPU.
// Holds the COP1 instruction field codes, exception bit indices, the
// canonical NaN/infinity encodings and the common round-and-pack helper
// used by both the adder and the multiplier paths.
package fpu_pkg;

   // instr[31:26] for every coprocessor-1 instruction
   localparam logic [5:0] OP_COP1  = 6'b010001;

   // instr[25:21]: F_OTHERS is the single-precision arithmetic format
   localparam logic [4:0] F_OTHERS = 5'b10000;
   localparam logic [4:0] F_MFC1   = 5'b00000;
   localparam logic [4:0] F_MTC1   = 5'b00100;

   // instr[5:0] arithmetic selects
   localparam logic [5:0] FN_ADD = 6'b000000;
   localparam logic [5:0] FN_SUB = 6'b000001;
   localparam logic [5:0] FN_MUL = 6'b000010;
   localparam logic [5:0] FN_ABS = 6'b000101;
   localparam logic [5:0] FN_NEG = 6'b000111;

   // exception vector bit positions
   localparam int EXC_OVF = 0;
   localparam int EXC_UNF = 1;
   localparam int EXC_INV = 2;
   localparam int EXC_UNS = 3;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] NEG_INF = 32'hFF800000;

   typedef struct packed {
      logic [31:0] value;
      logic        ovf;
      logic        unf;
   } pack_t;

   // Round-to-nearest-even and pack. mant holds the normalised significand
   // with the hidden bit at [26], fraction at [25:3] and guard/round/sticky
   // at [2:0]. exp_in is the biased exponent before rounding; anything at
   // or below zero would be denormal and is flushed to signed zero.
   function automatic pack_t fp_pack(input logic sign,
                                     input logic signed [9:0] exp_in,
                                     input logic [26:0] mant);
      logic              round_up;
      logic [24:0]       mant_r;
      logic signed [9:0] exp_r;
      pack_t             pk;
      round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
      mant_r   = {1'b0, mant[26:3]} + {24'd0, round_up};
      exp_r    = exp_in;
      // rounding carried out of the significand: renormalise
      if (mant_r[24]) begin
         mant_r = mant_r >> 1;
         exp_r  = exp_in + 10'sd1;
      end
      pk = '0;
      if (exp_in <= 10'sd0) begin
         pk.value = {sign, 31'd0};
         pk.unf   = 1'b1;
      end else if (exp_r >= 10'sd255) begin
         pk.value = sign ? NEG_INF : POS_INF;
         pk.ovf   = 1'b1;
      end else begin
         pk.value = {sign, exp_r[7:0], mant_r[22:0]};
      end
      return pk;
   endfunction

endpackage

// File: rtl/fpu_unit_cmp.sv
// fp_cmp -- combinational single-precision comparator.
// Ports:
//   a, b : IEEE-754 single operands
//   eq   : bit patterns equal or both zero (+0 == -0); never true for NaN
//   lt   : a < b in sign-magnitude order; false if either is NaN or both zero
module fp_cmp (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        eq,
   output logic        lt
);

   logic nan_a, nan_b, zero_a, zero_b;

   assign nan_a  = (&a[30:23]) & (|a[22:0]);
   assign nan_b  = (&b[30:23]) & (|b[22:0]);
   assign zero_a = ~|a[30:0];
   assign zero_b = ~|b[30:0];

   always_comb begin
      eq = 1'b0;
      lt = 1'b0;
      if (!nan_a && !nan_b) begin
         eq = (a == b) || (zero_a && zero_b);
         if (!(zero_a && zero_b)) begin
            if (a[31] != b[31])
               lt = a[31];
            else if (!a[31])
               lt = a[30:0] < b[30:0];
            else
               // both negative: larger magnitude is the smaller value
               lt = a[30:0] > b[30:0];
         end
      end
   end

endmodule

// File: rtl/fpu_unit.sv
// fpu_unit -- single-precision COP1 execution unit.
// Decodes opcode/fmt/funct, performs add/sub/mul/abs/neg and the mfc1/mtc1
// moves, and registers result, exception flags and the eq/lt compare flags
// one cycle after in_valid.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   in_valid         : operands and instruction fields valid this cycle
//   opcode/fmt/funct : instr[31:26] / instr[25:21] / instr[5:0]
//   a, b             : fs and ft operands (b is the integer source for mtc1)
//   out_valid        : outputs refreshed on the previous edge
//   result           : IEEE-754 single result
//   exception        : {unsupported, invalid, underflow, overflow}
//   eq, lt           : a == b, a < b
module fpu_unit
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [5:0]  opcode,
   input  logic [4:0]  fmt,
   input  logic [5:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result,
   output logic [3:0]  exception,
   output logic        eq,
   output logic        lt
);

   // ---------------- operand unpack (denormals read as zero) ----------------
   logic [7:0]  exp_a, exp_b;
   logic [23:0] man_a, man_b;
   logic        special_in;

   assign exp_a      = a[30:23];
   assign exp_b      = b[30:23];
   assign man_a      = (exp_a == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
   assign man_b      = (exp_b == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
   assign special_in = (&exp_a) | (&exp_b);

   // ---------------- add / sub ----------------
   logic              sign_b_eff, sign_big, sign_small;
   logic [7:0]        e_big, e_small, e_diff;
   logic [23:0]       m_big, m_small;
   logic [50:0]       shift_wide;
   logic [26:0]       m_aligned;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic [26:0]       sum_norm;
   logic signed [9:0] sum_exp;
   pack_t             add_pk;

   always_comb begin
      sign_b_eff = b[31] ^ (funct == FN_SUB);
      // order by magnitude so the subtraction never goes negative
      if ({exp_a, man_a} >= {exp_b, man_b}) begin
         sign_big = a[31];      e_big = exp_a;   m_big = man_a;
         sign_small = sign_b_eff; e_small = exp_b; m_small = man_b;
      end else begin
         sign_big = sign_b_eff; e_big = exp_b;   m_big = man_b;
         sign_small = a[31];    e_small = exp_a; m_small = man_a;
      end
      e_diff     = e_big - e_small;
      shift_wide = {m_small, 27'd0} >> e_diff;
      // beyond 26 places the whole smaller operand lands in the sticky bit
      if (e_diff > 8'd26)
         m_aligned = {26'd0, |m_small};
      else
         m_aligned = {shift_wide[50:25], |shift_wide[24:0]};

      if (sign_big == sign_small)
         sum = {1'b0, m_big, 3'b000} + {1'b0, m_aligned};
      else
         sum = {1'b0, m_big, 3'b000} - {1'b0, m_aligned};

      // leading-zero count relative to the hidden-bit position [26]
      lz = 5'd0;
      for (int i = 0; i <= 26; i++)
         if (sum[i]) lz = 5'(26 - i);

      if (sum[27]) begin
         sum_norm = {sum[27:2], |sum[1:0]};
         sum_exp  = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         sum_norm = sum[26:0] << lz;
         sum_exp  = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end
      add_pk = fp_pack(sign_big, sum_exp, sum_norm);
   end

   // ---------------- mul ----------------
   logic [47:0]       prod;
   logic [26:0]       prod_norm;
   logic signed [9:0] prod_exp;
   logic              prod_sign, prod_zero;
   pack_t             mul_pk;

   always_comb begin
      prod      = {24'd0, man_a} * {24'd0, man_b};
      prod_sign = a[31] ^ b[31];
      prod_zero = (exp_a == 8'd0) || (exp_b == 8'd0);
      prod_exp  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
      // product of two [1,2) significands lies in [1,4)
      if (prod[47]) begin
         prod_norm = {prod[47:22], |prod[21:0]};
         prod_exp  = prod_exp + 10'sd1;
      end else begin
         prod_norm = {prod[46:21], |prod[20:0]};
      end
      mul_pk = fp_pack(prod_sign, prod_exp, prod_norm);
   end

   // ---------------- result mux ----------------
   logic [31:0] result_next;
   logic [3:0]  exc_next;

   always_comb begin
      result_next = 32'd0;
      exc_next    = 4'd0;
      if (opcode == OP_COP1) begin
         case (fmt)
            F_MFC1: result_next = a;
            F_MTC1: result_next = b;
            F_OTHERS: begin
               case (funct)
                  FN_ADD, FN_SUB: begin
                     if (special_in) begin
                        result_next       = QNAN;
                        exc_next[EXC_INV] = 1'b1;
                     end else if (sum == 28'd0) begin
                        result_next = 32'd0;
                     end else begin
                        result_next       = add_pk.value;
                        exc_next[EXC_OVF] = add_pk.ovf;
                        exc_next[EXC_UNF] = add_pk.unf;
                     end
                  end
                  FN_MUL: begin
                     if (special_in) begin
                        result_next       = QNAN;
                        exc_next[EXC_INV] = 1'b1;
                     end else if (prod_zero) begin
                        result_next = {prod_sign, 31'd0};
                     end else begin
                        result_next       = mul_pk.value;
                        exc_next[EXC_OVF] = mul_pk.ovf;
                        exc_next[EXC_UNF] = mul_pk.unf;
                     end
                  end
                  FN_ABS:  result_next = {1'b0, a[30:0]};
                  FN_NEG:  result_next = {~a[31], a[30:0]};
                  default: exc_next[EXC_UNS] = 1'b1;
               endcase
            end
            default: exc_next[EXC_UNS] = 1'b1;
         endcase
      end
   end

   // ---------------- compare ----------------
   logic eq_next, lt_next;

   fp_cmp u_cmp (
      .a  (a),
      .b  (b),
      .eq (eq_next),
      .lt (lt_next)
   );

   // ---------------- output registers ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         result    <= 32'd0;
         exception <= 4'd0;
         eq        <= 1'b0;
         lt        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result    <= result_next;
            exception <= exc_next;
            eq        <= eq_next;
            lt        <= lt_next;
         end
      end
   end

endmodule

// File: tb/tb_fpu_unit.sv
// tb_fpu_unit -- table-driven, scoreboarded bench for fpu_unit.
module tb_fpu_unit;

   localparam logic [5:0] COP1  = 6'b010001;
   localparam logic [5:0] NOP   = 6'b000000;
   localparam logic [4:0] ARITH = 5'b10000;
   localparam logic [4:0] MFC1  = 5'b00000;
   localparam logic [4:0] MTC1  = 5'b00100;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  fmt;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  exc;
      logic        eq;
      logic        lt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [4:0]  fmt;
   logic [5:0]  funct;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] result;
   logic [3:0]  exception;
   logic        eq, lt;

   int   n_pass = 0;
   int   n_total = 0;
   int   n_txn = 0;
   vec_t vecs[$];
   vec_t exp_q[$];
   vec_t mon_e;

   fpu_unit dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .opcode    (opcode),
      .fmt       (fmt),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .exception (exception),
      .eq        (eq),
      .lt        (lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, req);
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [4:0] f, input logic [5:0] fn,
                               input logic [31:0] va, input logic [31:0] vb, input logic [31:0] r,
                               input logic [3:0] x, input logic e, input logic l);
      vec_t v;
      v.opcode = op; v.fmt = f; v.funct = fn; v.a = va; v.b = vb;
      v.res = r; v.exc = x; v.eq = e; v.lt = l;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      opcode = v.opcode; fmt = v.fmt; funct = v.funct; a = v.a; b = v.b;
      in_valid = 1'b1;
   endtask

   // scoreboard: pop one expectation per out_valid cycle
   always @(posedge clk) begin
      #1;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", result, mon_e.res);
            chk("exception", 32'(exception), 32'(mon_e.exc));
            chk("eq", 32'(eq), 32'(mon_e.eq));
            chk("lt", 32'(lt), 32'(mon_e.lt));
            $display("txn %0d: a=%08h b=%08h result=%08h exc=%h eq=%b lt=%b",
                     n_txn, mon_e.a, mon_e.b, result, exception, eq, lt);
            n_txn++;
         end
      end
   end

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_exception"}, 32'(exception), 32'd0);
      chk({tag, "_eq"}, 32'(eq), 32'd0);
      chk({tag, "_lt"}, 32'(lt), 32'd0);
   endtask

   initial begin
      //              op    fmt    funct      a             b             result        exc  eq    lt
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, ARITH, 6'h02, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, ARITH, 6'h02, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'h1, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h01, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0, 1'b1, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h07, 32'h40400000, 32'h00000000, 32'hC0400000, 4'h0, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h05, 32'hBF800000, 32'h00000000, 32'h3F800000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, MFC1,  6'h00, 32'h12345678, 32'h00000000, 32'h12345678, 4'h0, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, MTC1,  6'h00, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h3F, 32'h00000000, 32'h80000000, 32'h00000000, 4'h8, 1'b1, 1'b0));
      vecs.push_back(mk(NOP,  ARITH, 6'h00, 32'h3F800000, 32'h40000000, 32'h00000000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(NOP,  ARITH, 6'h00, 32'hBF800000, 32'h3F800000, 32'h00000000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 4'h4, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, 5'h01, 6'h00, 32'h40000000, 32'h40000000, 32'h00000000, 4'h8, 1'b1, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h02, 32'h00800000, 32'h00800000, 32'h00000000, 4'h2, 1'b1, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h01, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h4B800000, 32'h3F800000, 32'h4B800000, 4'h0, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h4B800001, 32'h3F800000, 32'h4B800002, 4'h0, 1'b0, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h80000000, 32'h80000000, 32'h00000000, 4'h0, 1'b1, 1'b0));
      vecs.push_back(mk(COP1, ARITH, 6'h02, 32'hC0000000, 32'h3FC00000, 32'hC0400000, 4'h0, 1'b0, 1'b1));
      vecs.push_back(mk(COP1, ARITH, 6'h00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h1, 1'b1, 1'b0));

      rstn = 1'b0; in_valid = 1'b0;
      opcode = '0; fmt = '0; funct = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;

      // back-to-back issue, one vector per cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // idle cycle: valid drops, data holds the last result
      @(posedge clk); #2;
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_hold_result", result, vecs[vecs.size()-1].res);
      chk("idle_hold_exception", 32'(exception), 32'(vecs[vecs.size()-1].exc));

      // reset between issue and the capturing edge: op discarded, outputs clear at once
      @(negedge clk);
      drive(vecs[0]);
      #2 rstn = 1'b0;
      #1 chk_all_zero("async_reset");
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(posedge clk); #2;
         chk("post_reset_out_valid", 32'(out_valid), 32'd0);
      end

      // recovery after reset
      @(negedge clk);
      drive(vecs[1]);
      exp_q.push_back(vecs[1]);
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
